// File: rtl/dpi_flow_scheduler_pkg.sv
// Shared types and defaults for the DPI flow scheduler.
// Holds the FSM state enum and sizing constants.
package dpi_flow_scheduler_pkg;

  localparam int NREQ_DEF = 4;
  localparam int NCTX_DEF = 16;
  localparam int SW_DEF   = 11;
  localparam int CW       = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_SAVE
  } state_t;

endpackage

// File: rtl/dpi_flow_scheduler_arb.sv
// Round-robin arbiter: first requester at or after ptr.
// Ports: req, ptr in; grant (one-hot), grant_idx out.
module rr_arbiter_nreq
  import dpi_flow_scheduler_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [N-1:0] w_rot;

  // Rotate so bit k of w_rot is requester (ptr+k) mod N.
  assign w_rot = N'({req, req} >> ptr);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    // Descending scan: the lowest rotated position wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        grant_idx = IW'((int'(ptr) + k) % N);
      end
    end
    if (|req) begin
      grant = N'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/dpi_flow_scheduler.sv
// Time-shares one DFA engine among byte-stream requesters per packet.
// Ports: req_* streams, clr_*, eng_* engine link, match_*, busy.
module dpi_flow_scheduler
  import dpi_flow_scheduler_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NCTX = NCTX_DEF,
  parameter int SW   = SW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_vld,
  input  logic [8*NREQ-1:0]  req_char,
  input  logic [NREQ-1:0]    req_last,
  input  logic [CW*NREQ-1:0] req_ctx,
  output logic [NREQ-1:0]    req_rdy,
  input  logic               clr_vld,
  input  logic [CW-1:0]      clr_ctx,
  output logic [7:0]         eng_char,
  output logic               eng_char_vld,
  output logic [SW-1:0]      eng_state_in,
  output logic               eng_state_in_vld,
  input  logic [SW-1:0]      eng_state_out,
  input  logic               eng_accept,
  output logic               match_vld,
  output logic [$clog2(NREQ)-1:0] match_req,
  output logic [CW-1:0]      match_ctx,
  output logic               busy
);

  localparam int GW = $clog2(NREQ);

  state_t         r_state;
  logic [GW-1:0]  r_ptr;
  logic [GW-1:0]  r_gnt;
  logic [CW-1:0]  r_ctx;
  logic [SW-1:0]  r_tbl [NCTX];
  logic           r_match_vld;
  logic [GW-1:0]  r_match_req;
  logic [CW-1:0]  r_match_ctx;

  logic [NREQ-1:0] w_arb_gnt;
  logic [GW-1:0]   w_arb_idx;
  logic [CW-1:0]   w_new_ctx;
  logic            w_g_vld;
  logic            w_g_last;
  logic [7:0]      w_g_char;
  logic            w_stream;
  logic            w_load;
  logic            w_beat;

  rr_arbiter_nreq #(
    .N  (NREQ),
    .IW (GW)
  ) u_arb (
    .req       (req_vld),
    .ptr       (r_ptr),
    .grant     (w_arb_gnt),
    .grant_idx (w_arb_idx)
  );

  always_comb begin
    w_g_vld   = 1'b0;
    w_g_last  = 1'b0;
    w_g_char  = '0;
    w_new_ctx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == r_gnt) begin
        w_g_vld  = req_vld[i];
        w_g_last = req_last[i];
        w_g_char = req_char[8*i +: 8];
      end
      if (w_arb_gnt[i]) begin
        w_new_ctx = req_ctx[CW*i +: CW];
      end
    end
  end

  assign w_stream = (r_state == ST_STREAM);
  assign w_load   = (r_state == ST_LOAD);
  assign w_beat   = w_stream & w_g_vld;

  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rdy[i] = w_beat && (GW'(i) == r_gnt);
    end
  end

  assign eng_char         = w_stream ? w_g_char : 8'h00;
  assign eng_char_vld     = w_beat;
  // Table read sees the pre-clear value if a clear hits this edge.
  assign eng_state_in     = w_load ? r_tbl[r_ctx] : '0;
  assign eng_state_in_vld = w_load;
  assign match_vld        = r_match_vld;
  assign match_req        = r_match_req;
  assign match_ctx        = r_match_ctx;
  assign busy             = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_ctx       <= '0;
      r_match_vld <= 1'b0;
      r_match_req <= '0;
      r_match_ctx <= '0;
      for (int i = 0; i < NCTX; i++) begin
        r_tbl[i] <= '0;
      end
    end else begin
      r_match_vld <= w_beat && eng_accept;
      if (w_beat && eng_accept) begin
        r_match_req <= r_gnt;
        r_match_ctx <= r_ctx;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (|req_vld) begin
            r_gnt   <= w_arb_idx;
            r_ctx   <= w_new_ctx;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: r_state <= ST_STREAM;
        ST_STREAM: begin
          if (w_beat && w_g_last) begin
            r_state <= ST_SAVE;
          end
        end
        ST_SAVE: begin
          r_tbl[r_ctx] <= eng_state_out;
          r_ptr        <= GW'((int'(r_gnt) + 1) % NREQ);
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Placed last so a coincident clear overrides the SAVE write.
      if (clr_vld) begin
        r_tbl[clr_ctx] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dpi_flow_scheduler.sv
// Bench for dpi_flow_scheduler with a stand-in ftp_2 DFA engine.
// Packet-level reference model predicts grants, loads and matches.
module tb_dpi_flow_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld = '0;
  logic [31:0] req_char = '0;
  logic [3:0]  req_last = '0;
  logic [15:0] req_ctx = '0;
  logic [3:0]  req_rdy;
  logic        clr_vld = 1'b0;
  logic [3:0]  clr_ctx = '0;
  logic [7:0]  eng_char;
  logic        eng_char_vld;
  logic [10:0] eng_state_in;
  logic        eng_state_in_vld;
  logic [10:0] eng_state_out;
  logic        eng_accept;
  logic        match_vld;
  logic [1:0]  match_req;
  logic [3:0]  match_ctx;
  logic        busy;

  dpi_flow_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .req_vld          (req_vld),
    .req_char         (req_char),
    .req_last         (req_last),
    .req_ctx          (req_ctx),
    .req_rdy          (req_rdy),
    .clr_vld          (clr_vld),
    .clr_ctx          (clr_ctx),
    .eng_char         (eng_char),
    .eng_char_vld     (eng_char_vld),
    .eng_state_in     (eng_state_in),
    .eng_state_in_vld (eng_state_in_vld),
    .eng_state_out    (eng_state_out),
    .eng_accept       (eng_accept),
    .match_vld        (match_vld),
    .match_req        (match_req),
    .match_ctx        (match_ctx),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // ftp_2: "PASS", one whitespace, "%%"; state 7 = just accepted.
  function automatic int nxt(input int s, input logic [7:0] c);
    int t;
    bit ok;
    t = (s >= 7) ? 0 : s;
    case (t)
      0:       ok = (c == "P");
      1:       ok = (c == "A");
      2, 3:    ok = (c == "S");
      4:       ok = (c == 8'h20 || c == 8'h09);
      5, 6:    ok = (c == "%");
      default: ok = 1'b0;
    endcase
    if (ok) return t + 1;
    return (c == "P") ? 1 : 0;
  endfunction

  logic [10:0] e_st = '0;
  always @(posedge clk) begin
    if (eng_state_in_vld) e_st <= eng_state_in;
    else if (eng_char_vld) e_st <= 11'(nxt(int'(e_st), eng_char));
  end
  assign eng_state_out = e_st;
  assign eng_accept = eng_char_vld && (nxt(int'(e_st), eng_char) == 7);

  int checks = 0;
  int errors = 0;

  string p_str[$];
  int    p_req[$];
  int    p_ctx[$];
  bit    p_clr[$];
  bit    p_done[$];
  int    e_ord[$];
  int    e_load[$];
  bit [63:0] e_mt[$];
  int    m_tbl[16];
  int    m_ptr;
  int    d_pos[4];
  bit    d_st[4];
  bit    clr_flag;
  int    clr_c;
  bit    xm_vld;
  int    xm_req;
  int    xm_ctx;
  bit    gaps_en;
  int    g_load;
  bit    ab;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int head(input int r);
    for (int j = 0; j < p_req.size(); j++)
      if (!p_done[j] && p_req[j] == r) return j;
    return -1;
  endfunction

  task automatic add(input int r, input int c, input string s,
                     input bit clr);
    p_req.push_back(r);
    p_ctx.push_back(c);
    p_str.push_back(s);
    p_clr.push_back(clr);
    p_done.push_back(1'b0);
  endtask

  // Grant order: round robin over requesters with queued packets.
  task automatic plan();
    bit tk[64];
    int ptr;
    int s;
    int pick;
    int j;
    bit [63:0] mt;
    foreach (tk[i]) tk[i] = 1'b0;
    e_ord.delete();
    e_load.delete();
    e_mt.delete();
    ptr = m_ptr;
    for (int n = 0; n < p_req.size(); n++) begin
      pick = -1;
      for (int k = 0; k < 4 && pick < 0; k++)
        for (int q = 0; q < p_req.size() && pick < 0; q++)
          if (!tk[q] && p_req[q] == (ptr + k) % 4) pick = q;
      tk[pick] = 1'b1;
      e_ord.push_back(pick);
      ptr = (p_req[pick] + 1) % 4;
    end
    for (int n = 0; n < e_ord.size(); n++) begin
      j = e_ord[n];
      s = m_tbl[p_ctx[j]];
      e_load.push_back(s);
      mt = '0;
      for (int b = 0; b < p_str[j].len(); b++) begin
        s = nxt(s, p_str[j][b]);
        if (s == 7) mt[b] = 1'b1;
      end
      e_mt.push_back(mt);
      m_tbl[p_ctx[j]] = p_clr[j] ? 0 : s;
    end
    m_ptr = ptr;
  endtask

  task automatic drive();
    int j;
    for (int r = 0; r < 4; r++) begin
      j = head(r);
      if (j >= 0) begin
        req_vld[r] = (d_st[r] && gaps_en) ? ($urandom_range(0, 3) != 0) : 1'b1;
        req_char[8*r +: 8] = p_str[j][d_pos[r]];
        req_last[r] = (d_pos[r] == p_str[j].len() - 1);
        req_ctx[4*r +: 4] = 4'(p_ctx[j]);
      end else begin
        req_vld[r] = 1'b0;
        req_last[r] = 1'b0;
        req_char[8*r +: 8] = 8'h00;
      end
    end
    clr_vld = clr_flag;
    clr_ctx = 4'(clr_c);
    clr_flag = 1'b0;
  endtask

  task automatic run(input int budget, input int rst_after,
                     input bit spacing, output bit aborted);
    int ep, beats, nld, lastc, cur, j;
    logic [3:0] acc;
    logic [3:0] mask;
    bit adv;
    ep = 0; beats = 0; nld = 0; lastc = -1; aborted = 1'b0;
    plan();
    for (int cy = 0; cy < budget; cy++) begin
      if (ep >= e_ord.size() && !xm_vld && !clr_flag) break;
      drive();
      #1;
      cur = (ep < e_ord.size()) ? p_req[e_ord[ep]] : -1;
      j = (cur >= 0) ? e_ord[ep] : -1;
      mask = (cur >= 0) ? 4'(1 << cur) : 4'h0;
      acc = req_vld & req_rdy;
      chk("rdy_mask", req_rdy & ~mask, 0);
      chk("char_vld", eng_char_vld, acc != 0);
      chk("match_vld", match_vld, xm_vld);
      if (xm_vld) begin
        chk("match_req", match_req, xm_req);
        chk("match_ctx", match_ctx, xm_ctx);
      end
      xm_vld = 1'b0;
      if (eng_state_in_vld) begin
        nld++;
        g_load = int'(eng_state_in);
        chk("load_val", eng_state_in, (cur >= 0) ? e_load[ep] : -1);
      end
      adv = (acc != 0) && (cur >= 0);
      if (adv) begin
        chk("beat_req", acc, mask);
        chk("beat_char", eng_char, p_str[j][d_pos[cur]]);
        if (spacing && lastc >= 0) chk("spacing", cy - lastc, 4);
        lastc = cy;
        xm_vld = e_mt[ep][d_pos[cur]];
        xm_req = cur;
        xm_ctx = p_ctx[j];
        beats++;
      end
      @(posedge clk);
      if (adv) begin
        d_st[cur] = 1'b1;
        d_pos[cur]++;
        if (d_pos[cur] == p_str[j].len()) begin
          p_done[j] = 1'b1;
          d_pos[cur] = 0;
          d_st[cur] = 1'b0;
          if (p_clr[j]) begin
            clr_flag = 1'b1;
            clr_c = p_ctx[j];
          end
          ep++;
        end
      end
      if (rst_after > 0 && beats == rst_after) begin
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!aborted) begin
      chk("all_done", ep, e_ord.size());
      chk("load_count", nld, e_ord.size());
    end
    p_str.delete(); p_req.delete(); p_ctx.delete();
    p_clr.delete(); p_done.delete();
  endtask

  task automatic chk_idle();
    chk("rst_busy", busy, 0);
    chk("rst_rdy", req_rdy, 0);
    chk("rst_char", eng_char, 0);
    chk("rst_char_vld", eng_char_vld, 0);
    chk("rst_st_in", eng_state_in, 0);
    chk("rst_st_in_vld", eng_state_in_vld, 0);
    chk("rst_match_vld", match_vld, 0);
    chk("rst_match_req", match_req, 0);
    chk("rst_match_ctx", match_ctx, 0);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic do_reset(input bit keep_vld);
    if (!keep_vld) req_vld = '0;
    clr_vld = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle();
    rst = 1'b0;
    req_vld = '0;
    m_ptr = 0;
    foreach (m_tbl[i]) m_tbl[i] = 0;
    foreach (d_pos[i]) begin d_pos[i] = 0; d_st[i] = 1'b0; end
    xm_vld = 1'b0;
    clr_flag = 1'b0;
    @(negedge clk);
  endtask

  function automatic string rstr();
    string s;
    s = "";
    for (int i = 0; i < $urandom_range(1, 3); i++) begin
      case ($urandom_range(0, 8))
        0: s = {s, "P"};
        1: s = {s, "A"};
        2: s = {s, "S"};
        3: s = {s, " "};
        4: s = {s, "%"};
        5: s = {s, "x"};
        6: s = {s, "PASS "};
        7: s = {s, "%%"};
        default: s = {s, "PASS\t%%"};
      endcase
    end
    return s;
  endfunction

  initial begin
    rst = 1'b1;
    gaps_en = 1'b0;
    clr_c = 0;
    g_load = 0;
    @(negedge clk);
    do_reset(1'b0);

    add(0, 3, "PASS %%", 1'b0);
    run(200, 0, 1'b0, ab);

    add(1, 5, "PASS ", 1'b0);
    run(200, 0, 1'b0, ab);
    add(1, 5, "%%", 1'b0);
    run(200, 0, 1'b0, ab);
    chk("ctx5_restored_nonzero", g_load != 0, 1);

    do_reset(1'b0);
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 4; r++) add(r, r, "x", 1'b0);
    run(200, 0, 1'b1, ab);

    add(2, 5, "PASS ", 1'b1);
    run(200, 0, 1'b0, ab);
    add(2, 5, "%%", 1'b0);
    run(200, 0, 1'b0, ab);

    add(0, 2, "PASS", 1'b0);
    run(200, 2, 1'b0, ab);
    chk("abort_reached", ab, 1);
    @(negedge clk);
    do_reset(1'b1);
    add(0, 2, "%%", 1'b0);
    run(200, 0, 1'b0, ab);

    gaps_en = 1'b1;
    for (int rnd = 0; rnd < 8; rnd++) begin
      for (int n = 0; n < $urandom_range(4, 10); n++)
        add($urandom_range(0, 3), $urandom_range(0, 7), rstr(),
            $urandom_range(0, 5) == 0);
      run(3000, 0, 1'b0, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpi_flow_scheduler.md
DPI_FLOW_SCHEDULER -- requirements
Module: dpi_flow_scheduler

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of byte-stream requesters; NCTX, default 16, number of saved flow contexts; SW, default 11, DFA state width.
REQ-002 clk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_vld  in  NREQ  per-requester byte valid.
REQ-005 req_char  in  8*NREQ  per-requester byte.
REQ-006 req_last  in  NREQ  marks the final byte of a packet.
REQ-007 req_ctx  in  4*NREQ  context id of the packet; held stable while req_vld is high.
REQ-008 req_rdy  out  NREQ  byte accepted when req_vld and req_rdy are both high.
REQ-009 clr_vld, clr_ctx  in  1, 4  one-cycle request to zero one context entry.
REQ-010 eng_char, eng_char_vld  out  8, 1  drive the DFA engine char_in and char_in_vld.
REQ-011 eng_state_in, eng_state_in_vld  out  SW, 1  drive the DFA engine state overwrite.
REQ-012 eng_state_out, eng_accept  in  SW, 1  DFA engine current state and same-cycle accept.
REQ-013 match_vld, match_req, match_ctx  out  1, 2, 4  registered match report.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The block SHALL time-share one DFA engine among NREQ requesters at packet granularity, with per-context state held in an NCTX x SW table.
REQ-016 The FSM SHALL have 4 states: IDLE, LOAD, STREAM, SAVE.
REQ-017 IDLE: when any req_vld is high, the block SHALL grant the first requester at or after rr_ptr in round-robin order, latch grant and ctx, and go to LOAD. Otherwise it SHALL remain in IDLE.
REQ-018 LOAD (1 cycle): eng_state_in SHALL be table[ctx] and eng_state_in_vld SHALL be 1, then the FSM SHALL go to STREAM.
REQ-019 STREAM: eng_char SHALL be req_char[g]; eng_char_vld and req_rdy[g] SHALL equal req_vld[g]; all other req_rdy bits SHALL be 0; a beat with req_last SHALL move the FSM to SAVE.
REQ-020 SAVE (1 cycle): table[ctx] SHALL be written with eng_state_out; rr_ptr SHALL become g+1 mod NREQ; the FSM SHALL go to IDLE.
REQ-021 Outside STREAM, req_rdy, eng_char_vld and eng_state_in_vld SHALL be 0, except eng_state_in_vld in LOAD.
REQ-022 On an accepted beat with eng_accept=1, the block SHALL assert match_vld for exactly 1 cycle on the next clock, with match_req=g and match_ctx=ctx.
REQ-023 Per-packet overhead SHALL be exactly 3 cycles (IDLE, LOAD, SAVE); a 1-byte packet SHALL occupy 4 cycles.
REQ-024 Gaps in req_vld[g] during STREAM SHALL stall without leaving STREAM.
REQ-025 clr_vld SHALL zero table[clr_ctx] on the next clock in any state. If it coincides with a SAVE write to the same entry, the clear SHALL win. If it coincides with LOAD of the same entry, LOAD SHALL use the pre-clear value.
REQ-026 A requester whose req_vld drops in IDLE before grant SHALL simply not be granted; no state SHALL change.

Reset
REQ-027 On rst, the FSM SHALL go to IDLE; rr_ptr, grant, ctx and all table entries SHALL become 0; all outputs SHALL be 0.
REQ-028 A reset during STREAM SHALL abandon the packet without a SAVE write; the engine's own reset is outside this block.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the NREQ, NCTX and SW defaults, and the context-id width constant.
REQ-030 The round-robin arbiter SHALL be a sub-module rr_arbiter_nreq (inputs req and ptr, outputs grant one-hot and grant index); the context table and FSM SHALL stay in the top.

Verification (engine instance built for the ftp_2 pattern, which accepts on "PASS" then whitespace then "%%")
REQ-031 Requester 0, ctx 3, packet "PASS %%" with last on the final '%' -> single match_vld with match_req=0 and match_ctx=3, one cycle after the last beat.
REQ-032 Ctx 5 receives "PASS " (last on the space) then "%%" as a second packet -> table[5] nonzero after packet 1, and a match after packet 2 (state restored).
REQ-033 All 4 requesters continuously valid with 1-byte packets -> grants 0,1,2,3,0 in order, 4 cycles per packet, never two req_rdy bits high at once.
REQ-034 clr_vld on ctx 5 in the same cycle as the SAVE of ctx 5 -> table[5]=0, and a following "%%" packet on ctx 5 produces no match.
REQ-035 rst asserted mid-STREAM of "PASS" on ctx 2 -> next cycle busy=0 and all outputs 0; afterwards "%%" on ctx 2 produces no match.
